// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: shared state encodings and elaboration helpers for the sequential BCD converter
package bin2bcd_seq_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   // The largest magnitude is 2^W-1 unsigned, 2^(W-1) signed; 10^D saturates to avoid 64-bit overflow.
   function automatic bit digits_ok(input int w, input int d, input bit s);
      longint p = 1;
      longint need = s ? (longint'(1) << (w - 1)) : (longint'(1) << w);
      for (int i = 0; i < d; i++) p = (p < (longint'(1) << 40)) ? p * 10 : p;
      return s ? (p >= need) : (p > need);
   endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to a digit of 5 or more before the shift
module bcd_digit_adj (
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock shift-and-add-3 binary to BCD converter with valid/ready handshakes
module bin2bcd_seq
   import bin2bcd_seq_pkg::*;
#(
   parameter int W      = 8,
   parameter int D      = 3,
   parameter bit SIGNED = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   bin,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [4*D-1:0] bcd,
   output logic           sign,
   output logic           busy
);
   localparam int CW = clog2(W + 1);
   if (!digits_ok(W, D, SIGNED)) begin : g_bad_digits
      $error("bin2bcd_seq: D=%0d digits cannot hold W=%0d bit input", D, W);
   end
   logic [1:0]     state;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   sr;
   logic [4*D-1:0] dig;
   logic [4*D-1:0] dig_adj;
   logic           sgn;
   logic           neg;
   logic [W-1:0]   mag;
   for (genvar g = 0; g < D; g++) begin : g_adj
      bcd_digit_adj u_adj (.d(dig[4*g +: 4]), .q(dig_adj[4*g +: 4]));
   end
   // Most negative input negates to 2^(W-1), which is still correct read as unsigned W bits.
   assign neg       = SIGNED && bin[W-1];
   assign mag       = neg ? W'(-bin) : bin;
   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign bcd       = dig;
   assign sign      = sgn;
   // FSM, bit counter and the {digits, shift register} datapath.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         sr    <= '0;
         dig   <= '0;
         sgn   <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (in_valid) begin
            sr    <= mag;
            sgn   <= neg;
            dig   <= '0;
            cnt   <= CW'(W);
            state <= ST_SHIFT;
         end
      end else if (state == ST_SHIFT) begin
         dig   <= {dig_adj[4*D-2:0], sr[W-1]};
         sr    <= sr << 1;
         cnt   <= cnt - CW'(1);
         state <= (cnt == CW'(1)) ? ST_DONE : ST_SHIFT;
      end else begin
         state <= out_ready ? ST_IDLE : ST_DONE;
      end
   end
   // Every digit must stay a legal decimal digit throughout the conversion.
   always_ff @(posedge clk) begin
      for (int i = 0; i < D; i++) assert (!rst_n || dig[4*i +: 4] <= 4'd9);
   end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and sweep checks of bin2bcd_seq in three configurations
module tb_bin2bcd_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_sign, a_busy;
   logic [7:0] a_bin = 0;
   logic [11:0] a_bcd;
   logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_sign, b_busy;
   logic [15:0] b_bin = 0;
   logic [19:0] b_bcd;
   logic c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0, c_sign, c_busy;
   logic [7:0] c_bin = 0;
   logic [11:0] c_bcd;

   always #5 clk = ~clk;

   bin2bcd_seq #(.W(8), .D(3), .SIGNED(1'b0)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .bin(a_bin),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .bcd(a_bcd), .sign(a_sign), .busy(a_busy));
   bin2bcd_seq #(.W(16), .D(5), .SIGNED(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .bin(b_bin),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .bcd(b_bcd), .sign(b_sign), .busy(b_busy));
   bin2bcd_seq #(.W(8), .D(3), .SIGNED(1'b1)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .bin(c_bin),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .bcd(c_bcd), .sign(c_sign), .busy(c_busy));

   function automatic logic [12:0] model(input logic [7:0] v, input bit signed_mode);
      int n = signed_mode ? int'($signed(v)) : int'(v);
      logic s = (n < 0);
      logic [11:0] r = '0;
      n = s ? -n : n;
      for (int i = 0; i < 3; i++) begin
         r[4*i +: 4] = 4'(n % 10);
         n = n / 10;
      end
      return {s, r};
   endfunction

   task automatic conv_a(input logic [7:0] v, output logic [11:0] r, output logic s, output bit ok);
      @(negedge clk);
      a_bin = v;
      a_in_valid = 1;
      for (int i = 0; i < 40 && !a_in_ready; i++) @(negedge clk);
      @(negedge clk);
      a_in_valid = 0;
      for (int i = 0; i < 40 && !a_out_valid; i++) @(negedge clk);
      ok = a_out_valid;
      r = a_bcd;
      s = a_sign;
      a_out_ready = 1;
      @(negedge clk);
   endtask

   task automatic conv_c(input logic [7:0] v, output logic [11:0] r, output logic s, output bit ok);
      @(negedge clk);
      c_bin = v;
      c_in_valid = 1;
      for (int i = 0; i < 40 && !c_in_ready; i++) @(negedge clk);
      @(negedge clk);
      c_in_valid = 0;
      for (int i = 0; i < 40 && !c_out_valid; i++) @(negedge clk);
      ok = c_out_valid;
      r = c_bcd;
      s = c_sign;
      c_out_ready = 1;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({a_in_ready, a_out_valid, a_bcd, a_sign, a_busy} !== {1'b1, 1'b0, 12'h000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_a got rdy=%b vld=%b bcd=%h sign=%b busy=%b exp 1 0 000 0 0",
                  a_in_ready, a_out_valid, a_bcd, a_sign, a_busy);
      end
      checks++;
      if ({b_in_ready, b_out_valid, b_bcd, b_busy, c_in_ready, c_out_valid, c_bcd, c_sign, c_busy}
          !== {1'b1, 1'b0, 20'h0, 1'b0, 1'b1, 1'b0, 12'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_bc got b=%b%b%h%b c=%b%b%h%b%b", b_in_ready, b_out_valid, b_bcd, b_busy,
                  c_in_ready, c_out_valid, c_bcd, c_sign, c_busy);
      end
      rst_n = 1;
   endtask

   task automatic test_latency;
      @(negedge clk);
      a_out_ready = 1;
      a_bin = 8'd255;
      a_in_valid = 1;
      @(posedge clk);
      #1 a_in_valid = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (a_out_valid !== (k == 8)) begin
            errors++;
            $display("FAIL latency_edge%0d out_valid got %b exp %b", k, a_out_valid, k == 8);
         end
      end
      checks++;
      if ({a_sign, a_bcd} !== {1'b0, 12'h255}) begin
         errors++;
         $display("FAIL conv_255 got sign=%b bcd=%h exp 0 255", a_sign, a_bcd);
      end
      @(negedge clk);
      checks++;
      if ({a_out_valid, a_in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL valid_one_cycle got out_valid=%b in_ready=%b exp 0 1", a_out_valid, a_in_ready);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] vals [4] = '{16'd0, 16'd9, 16'd10, 16'd65535};
      logic [19:0] exps [4] = '{20'h00000, 20'h00009, 20'h00010, 20'h65535};
      time t_prev = 0;
      time t_acc;
      @(negedge clk);
      b_out_ready = 1;
      b_bin = vals[0];
      b_in_valid = 1;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 40 && !b_in_ready; k++) @(negedge clk);
         @(posedge clk);
         t_acc = $time;
         @(negedge clk);
         if (i < 3) b_bin = vals[i + 1];
         else b_in_valid = 0;
         for (int k = 0; k < 40 && !b_out_valid; k++) @(negedge clk);
         checks++;
         if (b_out_valid !== 1'b1 || b_bcd !== exps[i]) begin
            errors++;
            $display("FAIL b2b_%0d got valid=%b bcd=%h exp 1 %h", i, b_out_valid, b_bcd, exps[i]);
         end
         if (i > 0) begin
            checks++;
            if ((t_acc - t_prev) / 10 != 18) begin
               errors++;
               $display("FAIL b2b_period_%0d got %0d exp 18", i, (t_acc - t_prev) / 10);
            end
         end
         t_prev = t_acc;
         @(negedge clk);
      end
   endtask

   task automatic test_signed;
      logic [7:0] ins [4] = '{8'h80, 8'hFF, 8'h7F, 8'h00};
      logic [12:0] exps [4] = '{{1'b1, 12'h128}, {1'b1, 12'h001}, {1'b0, 12'h127}, {1'b0, 12'h000}};
      logic [11:0] r;
      logic s;
      bit ok;
      for (int i = 0; i < 4; i++) begin
         conv_c(ins[i], r, s, ok);
         checks++;
         if (!ok || {s, r} !== exps[i]) begin
            errors++;
            $display("FAIL signed_%h got ok=%b sign=%b bcd=%h exp sign=%b bcd=%h",
                     ins[i], ok, s, r, exps[i][12], exps[i][11:0]);
         end
      end
   endtask

   task automatic test_backpressure;
      @(negedge clk);
      a_out_ready = 0;
      a_bin = 8'd77;
      a_in_valid = 1;
      @(negedge clk);
      a_in_valid = 0;
      for (int k = 0; k < 40 && !a_out_valid; k++) @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         a_in_valid = k[0];
         a_bin = 8'd3;
         @(negedge clk);
         checks++;
         if ({a_out_valid, a_in_ready, a_bcd} !== {1'b1, 1'b0, 12'h077}) begin
            errors++;
            $display("FAIL stall_%0d got valid=%b rdy=%b bcd=%h exp 1 0 077", k, a_out_valid, a_in_ready, a_bcd);
         end
      end
      a_in_valid = 0;
      a_out_ready = 1;
      @(negedge clk);
      checks++;
      if ({a_out_valid, a_in_ready, a_bcd} !== {1'b0, 1'b1, 12'h077}) begin
         errors++;
         $display("FAIL release got valid=%b rdy=%b bcd=%h exp 0 1 077", a_out_valid, a_in_ready, a_bcd);
      end
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b0) begin
         errors++;
         $display("FAIL release_idle busy got %b exp 0", a_busy);
      end
   endtask

   task automatic test_reset_mid;
      logic [11:0] r;
      logic s;
      bit ok;
      int spur = 0;
      @(negedge clk);
      a_out_ready = 1;
      a_bin = 8'd200;
      a_in_valid = 1;
      @(posedge clk);
      #1 a_in_valid = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({a_in_ready, a_out_valid, a_busy, a_bcd} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
         errors++;
         $display("FAIL mid_reset got rdy=%b valid=%b busy=%b bcd=%h exp 1 0 0 000",
                  a_in_ready, a_out_valid, a_busy, a_bcd);
      end
      rst_n = 1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         spur += a_out_valid;
      end
      checks++;
      if (spur != 0) begin
         errors++;
         $display("FAIL mid_reset_no_valid got %0d pulses exp 0", spur);
      end
      conv_a(8'd42, r, s, ok);
      checks++;
      if (!ok || {s, r} !== {1'b0, 12'h042}) begin
         errors++;
         $display("FAIL after_reset_42 got ok=%b sign=%b bcd=%h exp 0 042", ok, s, r);
      end
   endtask

   task automatic test_sweep;
      logic [11:0] r;
      logic s;
      bit ok;
      for (int v = 0; v < 256; v++) begin
         conv_a(8'(v), r, s, ok);
         checks++;
         if (!ok || {s, r} !== model(8'(v), 1'b0)) begin
            errors++;
            $display("FAIL sweep_u_%0d got ok=%b %b_%h exp %h", v, ok, s, r, model(8'(v), 1'b0));
         end
         conv_c(8'(v), r, s, ok);
         checks++;
         if (!ok || {s, r} !== model(8'(v), 1'b1)) begin
            errors++;
            $display("FAIL sweep_s_%0d got ok=%b %b_%h exp %h", v, ok, s, r, model(8'(v), 1'b1));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_signed();
      test_backpressure();
      test_reset_mid();
      test_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
